regfile_wb_arbiter: RTL and testbench

- Shares the register file's single write port between three writeback requesters: ALU result, memory load return, and link write (JAL/JALR/BGEZAL/BLTZAL to $31).
- Arbitrates round-robin and drives a registered write port into the register file.
- Keeps a 32-entry load scoreboard so decode can stall on registers with an outstanding load.
- Sits between the execute/memory stages and the register file.

---
 rtl/regfile_wb_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// Round-robin writeback arbiter (ALU / load return / link) with a registered
// register-file write port and a load scoreboard. Optional macro: WB_BYPASS_EN.
module regfile_wb_arbiter #(
  parameter int DATA_WIDTH  = 32,
  parameter int INDEX_WIDTH = 5,
  parameter int LINK_INDEX  = 31
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   alu_valid,
  output logic                   alu_ready,
  input  logic [INDEX_WIDTH-1:0] alu_index,
  input  logic [DATA_WIDTH-1:0]  alu_data,
  input  logic                   mem_valid,
  output logic                   mem_ready,
  input  logic [INDEX_WIDTH-1:0] mem_index,
  input  logic [DATA_WIDTH-1:0]  mem_data,
  input  logic                   link_valid,
  output logic                   link_ready,
  input  logic [DATA_WIDTH-1:0]  link_data,
  input  logic                   issue_load_valid,
  input  logic [INDEX_WIDTH-1:0] issue_load_index,
  input  logic [INDEX_WIDTH-1:0] rs_index,
  input  logic [INDEX_WIDTH-1:0] rt_index,
  output logic                   rs_busy,
  output logic                   rt_busy,
`ifdef WB_BYPASS_EN
  output logic                   rs_fwd_valid,
  output logic                   rt_fwd_valid,
  output logic [DATA_WIDTH-1:0]  rs_fwd_data,
  output logic [DATA_WIDTH-1:0]  rt_fwd_data,
`endif
  output logic                   write_enable,
  output logic [INDEX_WIDTH-1:0] write_index,
  output logic [DATA_WIDTH-1:0]  write_data
);

  localparam int SB_ENTRIES = 1 << INDEX_WIDTH;
  localparam logic [1:0] SRC_ALU = 2'd0;
  localparam logic [1:0] SRC_MEM = 2'd1;
  localparam logic [INDEX_WIDTH-1:0] LINK_IDX = INDEX_WIDTH'(LINK_INDEX);
  localparam logic [INDEX_WIDTH-1:0] IDX_ZERO = '0;

  logic [1:0]             last_grant_q, last_grant_d;
  logic                   write_enable_q, write_enable_d;
  logic [INDEX_WIDTH-1:0] write_index_q, write_index_d;
  logic [DATA_WIDTH-1:0]  write_data_q, write_data_d;
  logic [SB_ENTRIES-1:0]  sb_q, sb_d;
`ifndef WB_BYPASS_EN
  logic                   clr_pend_q, clr_pend_d;
  logic [INDEX_WIDTH-1:0] clr_idx_q, clr_idx_d;
`endif

  logic [2:0]             grant_s;
  logic [INDEX_WIDTH-1:0] sel_index_s;
  logic [DATA_WIDTH-1:0]  sel_data_s;
  logic                   mem_xfer_s;

  // Round-robin search starting after the last granted requester
  always_comb begin
    grant_s = 3'b000;
    if (reset) begin
      case (last_grant_q)
        SRC_ALU: begin
          if (mem_valid)       grant_s = 3'b010;
          else if (link_valid) grant_s = 3'b100;
          else if (alu_valid)  grant_s = 3'b001;
          else                 grant_s = 3'b000;
        end
        SRC_MEM: begin
          if (link_valid)      grant_s = 3'b100;
          else if (alu_valid)  grant_s = 3'b001;
          else if (mem_valid)  grant_s = 3'b010;
          else                 grant_s = 3'b000;
        end
        default: begin
          if (alu_valid)       grant_s = 3'b001;
          else if (mem_valid)  grant_s = 3'b010;
          else if (link_valid) grant_s = 3'b100;
          else                 grant_s = 3'b000;
        end
      endcase
    end else begin
      grant_s = 3'b000;
    end
  end

  assign alu_ready  = grant_s[0];
  assign mem_ready  = grant_s[1];
  assign link_ready = grant_s[2];
  assign mem_xfer_s = grant_s[1] && (mem_index != IDX_ZERO);

  // Next-state for pointer, write port and scoreboard
  always_comb begin
    sel_index_s    = IDX_ZERO;
    sel_data_s     = '0;
    last_grant_d   = last_grant_q;
    write_index_d  = write_index_q;
    write_data_d   = write_data_q;
    sb_d           = sb_q;
    if (grant_s[0]) begin
      sel_index_s  = alu_index;
      sel_data_s   = alu_data;
      last_grant_d = 2'd0;
    end else if (grant_s[1]) begin
      sel_index_s  = mem_index;
      sel_data_s   = mem_data;
      last_grant_d = 2'd1;
    end else if (grant_s[2]) begin
      sel_index_s  = LINK_IDX;
      sel_data_s   = link_data;
      last_grant_d = 2'd2;
    end else begin
      sel_index_s  = IDX_ZERO;
      sel_data_s   = '0;
    end
    // $0 transfers handshake but never strobe the register file
    write_enable_d = (|grant_s) && (sel_index_s != IDX_ZERO);
    if (write_enable_d) begin
      write_index_d = sel_index_s;
      write_data_d  = sel_data_s;
    end else begin
      write_index_d = write_index_q;
      write_data_d  = write_data_q;
    end
`ifdef WB_BYPASS_EN
    if (mem_xfer_s) sb_d[mem_index] = 1'b0;
    else            sb_d = sb_d;
`else
    clr_pend_d = 1'b0;
    clr_idx_d  = clr_idx_q;
    if (clr_pend_q) sb_d[clr_idx_q] = 1'b0;
    else            sb_d = sb_d;
    // A load re-issued to the returning register keeps its bit set
    if (mem_xfer_s && !(issue_load_valid && issue_load_index == mem_index)) begin
      clr_pend_d = 1'b1;
      clr_idx_d  = mem_index;
    end else begin
      clr_pend_d = 1'b0;
    end
`endif
    if (issue_load_valid && issue_load_index != IDX_ZERO) sb_d[issue_load_index] = 1'b1;
    else                                                  sb_d = sb_d;
  end

  // State registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_grant_q   <= 2'd2;
      write_enable_q <= 1'b0;
      write_index_q  <= '0;
      write_data_q   <= '0;
      sb_q           <= '0;
`ifndef WB_BYPASS_EN
      clr_pend_q     <= 1'b0;
      clr_idx_q      <= '0;
`endif
    end else begin
      last_grant_q   <= last_grant_d;
      write_enable_q <= write_enable_d;
      write_index_q  <= write_index_d;
      write_data_q   <= write_data_d;
      sb_q           <= sb_d;
`ifndef WB_BYPASS_EN
      clr_pend_q     <= clr_pend_d;
      clr_idx_q      <= clr_idx_d;
`endif
    end
  end

  assign write_enable = write_enable_q;
  assign write_index  = write_index_q;
  assign write_data   = write_data_q;
  assign rs_busy      = sb_q[rs_index] && (rs_index != IDX_ZERO);
  assign rt_busy      = sb_q[rt_index] && (rt_index != IDX_ZERO);

`ifdef WB_BYPASS_EN
  assign rs_fwd_valid = write_enable_q && (write_index_q == rs_index) && (rs_index != IDX_ZERO);
  assign rt_fwd_valid = write_enable_q && (write_index_q == rt_index) && (rt_index != IDX_ZERO);
  assign rs_fwd_data  = write_data_q;
  assign rt_fwd_data  = write_data_q;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed test-plan steps followed by
// randomized traffic, all compared against a behavioural model.
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        alu_valid, mem_valid, link_valid, issue_load_valid;
  logic        alu_ready, mem_ready, link_ready, rs_busy, rt_busy;
  logic [4:0]  alu_index, mem_index, issue_load_index, rs_index, rt_index;
  logic [31:0] alu_data, mem_data, link_data;
  logic        write_enable;
  logic [4:0]  write_index;
  logic [31:0] write_data;
`ifdef WB_BYPASS_EN
  logic        rs_fwd_valid, rt_fwd_valid;
  logic [31:0] rs_fwd_data, rt_fwd_data;
`endif

  regfile_wb_arbiter dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_index(alu_index), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_index(mem_index), .mem_data(mem_data),
    .link_valid(link_valid), .link_ready(link_ready), .link_data(link_data),
    .issue_load_valid(issue_load_valid), .issue_load_index(issue_load_index),
    .rs_index(rs_index), .rt_index(rt_index), .rs_busy(rs_busy), .rt_busy(rt_busy),
`ifdef WB_BYPASS_EN
    .rs_fwd_valid(rs_fwd_valid), .rt_fwd_valid(rt_fwd_valid),
    .rs_fwd_data(rs_fwd_data), .rt_fwd_data(rt_fwd_data),
`endif
    .write_enable(write_enable), .write_index(write_index), .write_data(write_data)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model state: pointer, pending write, busy set, scheduled clear
  int          m_last;
  bit          m_we;
  logic [4:0]  m_widx;
  logic [31:0] m_wdata;
  bit          m_sb [32];
  bit          m_clr_pend;
  int          m_clr_idx;
  int          last_g;
  logic [2:0]  obs_rdy;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_last = 2; m_we = 1'b0; m_widx = 5'd0; m_wdata = 32'd0;
    m_clr_pend = 1'b0; m_clr_idx = 0;
    for (int i = 0; i < 32; i++) m_sb[i] = 1'b0;
  endtask

  // One clock: check outputs mid-cycle, then advance the model on the edge
  task automatic step();
    int g;
    int r;
    bit v [3];
    logic [4:0]  idx;
    logic [31:0] dat;
    @(negedge clk);
    v[0] = alu_valid; v[1] = mem_valid; v[2] = link_valid;
    g = -1;
    if (reset) begin
      for (int k = 0; k < 3; k++) begin
        r = (m_last + 1 + k) % 3;
        if (g < 0 && v[r]) g = r;
      end
    end
    obs_rdy = {link_ready, mem_ready, alu_ready};
    check("alu_ready",  64'(alu_ready),  64'(g == 0));
    check("mem_ready",  64'(mem_ready),  64'(g == 1));
    check("link_ready", 64'(link_ready), 64'(g == 2));
    check("rs_busy", 64'(rs_busy), 64'(m_sb[rs_index] && rs_index != 5'd0));
    check("rt_busy", 64'(rt_busy), 64'(m_sb[rt_index] && rt_index != 5'd0));
    check("write_enable", 64'(write_enable), 64'(m_we));
    check("write_index",  64'(write_index),  64'(m_widx));
    check("write_data",   64'(write_data),   64'(m_wdata));
`ifdef WB_BYPASS_EN
    check("rs_fwd_valid", 64'(rs_fwd_valid), 64'(m_we && m_widx == rs_index && rs_index != 5'd0));
    check("rt_fwd_valid", 64'(rt_fwd_valid), 64'(m_we && m_widx == rt_index && rt_index != 5'd0));
    if (rs_fwd_valid) check("rs_fwd_data", 64'(rs_fwd_data), 64'(m_wdata));
`endif
    last_g = g;
    @(posedge clk);
    if (reset) begin
      if (m_clr_pend) m_sb[m_clr_idx] = 1'b0;
      m_clr_pend = 1'b0;
      m_we = 1'b0;
      if (g >= 0) begin
        idx = (g == 0) ? alu_index : (g == 1) ? mem_index : 5'd31;
        dat = (g == 0) ? alu_data  : (g == 1) ? mem_data  : link_data;
        m_last = g;
        m_we = (idx != 5'd0);
        if (idx != 5'd0) begin m_widx = idx; m_wdata = dat; end
        if (g == 1 && mem_index != 5'd0) begin
`ifdef WB_BYPASS_EN
          m_sb[mem_index] = 1'b0;
`else
          if (!(issue_load_valid && issue_load_index == mem_index)) begin
            m_clr_pend = 1'b1; m_clr_idx = int'(mem_index);
          end
`endif
        end
      end
      if (issue_load_valid && issue_load_index != 5'd0) m_sb[issue_load_index] = 1'b1;
    end
    #1;
  endtask

  initial begin
    reset = 1'b0; m_reset();
    alu_valid = 1'b0; mem_valid = 1'b0; link_valid = 1'b0; issue_load_valid = 1'b0;
    alu_index = 5'd0; mem_index = 5'd0; issue_load_index = 5'd0; rs_index = 5'd0; rt_index = 5'd0;
    alu_data = 32'd0; mem_data = 32'd0; link_data = 32'd0;
    step(); step();
    reset = 1'b1;

    // Single ALU write, latency one cycle
    alu_valid = 1'b1; alu_index = 5'd5; alu_data = 32'hDEADBEEF;
    step();
    check("tp1_alu_ready", 64'(obs_rdy[0]), 64'd1);
    alu_valid = 1'b0;
    check("tp1_we", 64'(write_enable), 64'd1);
    check("tp1_idx", 64'(write_index), 64'd5);
    check("tp1_data", 64'(write_data), 64'hDEADBEEF);

    // Point the arbiter at LINK so ALU leads the three-way contest
    link_valid = 1'b1; link_data = 32'h100; step(); link_valid = 1'b0;
    alu_valid = 1'b1; alu_index = 5'd3; alu_data = 32'h11;
    mem_valid = 1'b1; mem_index = 5'd4; mem_data = 32'h22;
    link_valid = 1'b1; link_data = 32'h33;
    step(); alu_valid = 1'b0;
    check("tp2_w0_idx", 64'(write_index), 64'd3);
    check("tp2_w0_data", 64'(write_data), 64'h11);
    step(); mem_valid = 1'b0;
    check("tp2_w1_idx", 64'(write_index), 64'd4);
    check("tp2_w1_data", 64'(write_data), 64'h22);
    step(); link_valid = 1'b0;
    check("tp2_w2_idx", 64'(write_index), 64'd31);
    check("tp2_w2_data", 64'(write_data), 64'h33);

    // $0 write: handshake without strobe
    alu_valid = 1'b1; alu_index = 5'd0; alu_data = 32'hFFFFFFFF;
    step(); alu_valid = 1'b0;
    check("tp3_ready", 64'(obs_rdy[0]), 64'd1);
    check("tp3_we", 64'(write_enable), 64'd0);

    // Load scoreboard set and clear
    issue_load_valid = 1'b1; issue_load_index = 5'd8; rs_index = 5'd8;
    step(); issue_load_valid = 1'b0;
    check("tp4_busy_set", 64'(rs_busy), 64'd1);
    mem_valid = 1'b1; mem_index = 5'd8; mem_data = 32'h1234;
    step(); mem_valid = 1'b0;
    check("tp4_we", 64'(write_enable), 64'd1);
`ifdef WB_BYPASS_EN
    check("tp4_busy_wcycle", 64'(rs_busy), 64'd0);
    check("tp4_fwd_valid", 64'(rs_fwd_valid), 64'd1);
    check("tp4_fwd_data", 64'(rs_fwd_data), 64'h1234);
`else
    check("tp4_busy_wcycle", 64'(rs_busy), 64'd1);
`endif
    step();
    check("tp4_busy_after", 64'(rs_busy), 64'd0);

    // Simultaneous issue and return to the same register: set wins
    issue_load_valid = 1'b1; issue_load_index = 5'd9;
    mem_valid = 1'b1; mem_index = 5'd9; mem_data = 32'h99; rt_index = 5'd9;
    step(); issue_load_valid = 1'b0; mem_valid = 1'b0;
    step(); step();
    check("tp5_bit9", 64'(rt_busy), 64'd1);

    // Reset right after a grant drops the pending write
    alu_valid = 1'b1; alu_index = 5'd7; alu_data = 32'h77;
    step(); alu_valid = 1'b0;
    reset = 1'b0; m_reset(); #1;
    check("tp6_we", 64'(write_enable), 64'd0);
    check("tp6_sb9", 64'(rt_busy), 64'd0);
    step(); step();
    reset = 1'b1;
    alu_valid = 1'b1; mem_valid = 1'b1; link_valid = 1'b1;
    alu_index = 5'd1; mem_index = 5'd2; link_data = 32'h44;
    step(); alu_valid = 1'b0;
    check("tp6_alu_first", 64'(obs_rdy), 64'd1);

    // Randomized traffic respecting the hold-until-ready rule
    for (int c = 0; c < 500; c++) begin
      if (!alu_valid || last_g == 0) begin
        alu_valid = 1'($urandom_range(0, 1)); alu_index = 5'($urandom_range(0, 31)); alu_data = $urandom;
      end
      if (!mem_valid || last_g == 1) begin
        mem_valid = 1'($urandom_range(0, 1)); mem_index = 5'($urandom_range(0, 31)); mem_data = $urandom;
      end
      if (!link_valid || last_g == 2) begin
        link_valid = 1'($urandom_range(0, 1)); link_data = $urandom;
      end
      issue_load_valid = ($urandom_range(0, 2) == 0);
      issue_load_index = 5'($urandom_range(0, 31));
      rs_index = 5'($urandom_range(0, 31));
      rt_index = 5'($urandom_range(0, 31));
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
